// File: rtl/id_stage_pipe.sv
// rtl/id_stage_pipe.sv - ARM-style decode stage with register file and ID/EX pipeline register
// Optional macro WB_BYPASS_EN forwards a same-cycle writeback into the operand reads.
module id_stage_pipe #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [31:0]       PC_in,
   input  logic [31:0]       Instruction,
   input  logic [3:0]        status,
   input  logic [3:0]        Dest_wb,
   input  logic [DATA_W-1:0] Result_WB,
   input  logic              writeBackEn,
   input  logic              Hazard,
   input  logic              freeze,
   input  logic              flush,
   output logic [3:0]        src1,
   output logic [3:0]        src2,
   output logic              has_src2,
   output logic              out_valid,
   output logic              WB_EN,
   output logic              MEM_R_EN,
   output logic              MEM_W_EN,
   output logic              B,
   output logic              S,
   output logic              imm,
   output logic [3:0]        EXE_CMD,
   output logic [31:0]       PC_out,
   output logic [DATA_W-1:0] Val_RN,
   output logic [DATA_W-1:0] Val_RM,
   output logic [3:0]        Dest,
   output logic [11:0]       shift_operand,
   output logic [31:0]       imm24_sext
);

   logic [3:0]        cond, opcode, rn_idx, rd_idx, rm_idx;
   logic [1:0]        mode;
   logic              i_bit, s_bit, is_store, cond_ok, issue;
   logic              z_f, c_f, n_f, v_f;
   logic              dec_valid, dec_wb, dec_mr, dec_mw, dec_b, dec_s, dec_imm;
   logic [3:0]        dec_cmd;
   logic [DATA_W-1:0] rf [NUM_REGS];
   logic [DATA_W-1:0] rn_val, rm_val;

   assign cond   = Instruction[31:28];
   assign mode   = Instruction[27:26];
   assign i_bit  = Instruction[25];
   assign opcode = Instruction[24:21];
   assign s_bit  = Instruction[20];
   assign rn_idx = Instruction[19:16];
   assign rd_idx = Instruction[15:12];
   assign rm_idx = Instruction[3:0];
   assign {z_f, c_f, n_f, v_f} = status;

   // Stores read Rd as the data to write, so the hazard unit must see it as a source.
   assign is_store = (mode == 2'b01) && !s_bit;
   assign src1     = rn_idx;
   assign src2     = is_store ? rd_idx : rm_idx;
   assign has_src2 = ~i_bit | is_store;

   always_comb begin : cond_eval
      cond_ok = 1'b1;
      case (cond)
         4'h0: cond_ok = z_f;
         4'h1: cond_ok = ~z_f;
         4'h2: cond_ok = c_f;
         4'h3: cond_ok = ~c_f;
         4'h4: cond_ok = n_f;
         4'h5: cond_ok = ~n_f;
         4'h6: cond_ok = v_f;
         4'h7: cond_ok = ~v_f;
         4'h8: cond_ok = c_f & ~z_f;
         4'h9: cond_ok = ~c_f | z_f;
         4'hA: cond_ok = (n_f == v_f);
         4'hB: cond_ok = (n_f != v_f);
         4'hC: cond_ok = ~z_f & (n_f == v_f);
         4'hD: cond_ok = z_f | (n_f != v_f);
         default: cond_ok = 1'b1;
      endcase
   end

   always_comb begin : decode
      dec_valid = 1'b1;
      dec_wb    = 1'b0;
      dec_mr    = 1'b0;
      dec_mw    = 1'b0;
      dec_b     = 1'b0;
      dec_s     = 1'b0;
      dec_imm   = 1'b0;
      dec_cmd   = 4'b0000;
      case (mode)
         2'b00: begin
            dec_imm = i_bit;
            dec_wb  = 1'b1;
            dec_s   = s_bit;
            case (opcode)
               4'b1101: dec_cmd = 4'b0001;
               4'b1111: dec_cmd = 4'b1001;
               4'b0100: dec_cmd = 4'b0010;
               4'b0101: dec_cmd = 4'b0011;
               4'b0010: dec_cmd = 4'b0100;
               4'b0110: dec_cmd = 4'b0101;
               4'b0000: dec_cmd = 4'b0110;
               4'b1100: dec_cmd = 4'b0111;
               4'b0001: dec_cmd = 4'b1000;
               4'b1010: begin dec_cmd = 4'b0100; dec_wb = 1'b0; end
               4'b1000: begin dec_cmd = 4'b0110; dec_wb = 1'b0; end
               default: begin dec_cmd = 4'b0000; dec_wb = 1'b0; dec_s = 1'b0; end
            endcase
         end
         2'b01: begin
            dec_cmd = 4'b0010;
            dec_imm = i_bit;
            dec_mr  = s_bit;
            dec_wb  = s_bit;
            dec_mw  = ~s_bit;
         end
         2'b10:   dec_b = 1'b1;
         default: dec_valid = 1'b0;
      endcase
   end

   assign issue = in_valid & ~Hazard & cond_ok & dec_valid;

   // Out-of-range writeback indices match no entry and are dropped naturally.
   always_ff @(posedge clk) begin : rf_write
      for (int i = 0; i < NUM_REGS; i++) begin
         if (rst)
            rf[i] <= '0;
         else if (writeBackEn && Dest_wb == 4'(i))
            rf[i] <= Result_WB;
      end
   end

   always_comb begin : rf_read
      rn_val = '0;
      rm_val = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (src1 == 4'(i)) rn_val = rf[i];
         if (src2 == 4'(i)) rm_val = rf[i];
      end
`ifdef WB_BYPASS_EN
      if (writeBackEn && int'(Dest_wb) < NUM_REGS) begin
         if (src1 == Dest_wb) rn_val = Result_WB;
         if (src2 == Dest_wb) rm_val = Result_WB;
      end
`endif
   end

   always_ff @(posedge clk) begin : idex_reg
      if (rst || flush || (!freeze && !issue)) begin
         out_valid     <= 1'b0;
         WB_EN         <= 1'b0;
         MEM_R_EN      <= 1'b0;
         MEM_W_EN      <= 1'b0;
         B             <= 1'b0;
         S             <= 1'b0;
         imm           <= 1'b0;
         EXE_CMD       <= 4'b0000;
         PC_out        <= '0;
         Val_RN        <= '0;
         Val_RM        <= '0;
         Dest          <= '0;
         shift_operand <= '0;
         imm24_sext    <= '0;
      end else if (!freeze) begin
         out_valid     <= 1'b1;
         WB_EN         <= dec_wb;
         MEM_R_EN      <= dec_mr;
         MEM_W_EN      <= dec_mw;
         B             <= dec_b;
         S             <= dec_s;
         imm           <= dec_imm;
         EXE_CMD       <= dec_cmd;
         PC_out        <= PC_in;
         Val_RN        <= rn_val;
         Val_RM        <= rm_val;
         Dest          <= rd_idx;
         shift_operand <= Instruction[11:0];
         imm24_sext    <= {{8{Instruction[23]}}, Instruction[23:0]};
      end
   end

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb/tb_id_stage_pipe.sv - random and directed bench for id_stage_pipe against a behavioural model
module tb_id_stage_pipe;

   typedef struct {
      logic        v, wb, mr, mw, b, s, imm;
      logic [3:0]  cmd, dest;
      logic [31:0] pc, rn, rm, simm;
      logic [11:0] sh;
   } bundle_t;

   logic        clk = 1'b0;
   logic        rst, in_valid, wbe, hazard, freeze, flush;
   logic [31:0] pc, instr, wres;
   logic [15:0] wres_s;
   logic [3:0]  status, dwb;

   logic [3:0]  b_src1, b_src2, s_src1, s_src2, b_cmd, s_cmd, b_dest, s_dest;
   logic        b_has2, s_has2, b_v, s_v, b_wb, s_wb, b_mr, s_mr, b_mw, s_mw;
   logic        b_b, s_b, b_s, s_s, b_imm, s_imm;
   logic [31:0] b_pc, s_pc, b_rn, b_rm, b_simm, s_simm;
   logic [15:0] s_rn, s_rm;
   logic [11:0] b_sh, s_sh;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_reg [2][16];
   bundle_t     exp_q [2];
   logic [3:0]  opc_tab [11] = '{4'hD, 4'hF, 4'h4, 4'h5, 4'h2, 4'h6, 4'h0, 4'hC, 4'h1, 4'hA, 4'h8};
   logic [3:0]  cmd_tab [11] = '{4'd1, 4'd9, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd4, 4'd6};

   assign wres_s = wres[15:0];

   always #5 clk = ~clk;

   id_stage_pipe u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .PC_in(pc), .Instruction(instr),
      .status(status), .Dest_wb(dwb), .Result_WB(wres), .writeBackEn(wbe),
      .Hazard(hazard), .freeze(freeze), .flush(flush),
      .src1(b_src1), .src2(b_src2), .has_src2(b_has2), .out_valid(b_v), .WB_EN(b_wb),
      .MEM_R_EN(b_mr), .MEM_W_EN(b_mw), .B(b_b), .S(b_s), .imm(b_imm), .EXE_CMD(b_cmd),
      .PC_out(b_pc), .Val_RN(b_rn), .Val_RM(b_rm), .Dest(b_dest),
      .shift_operand(b_sh), .imm24_sext(b_simm)
   );

   id_stage_pipe #(.DATA_W(16), .NUM_REGS(8)) u_small (
      .clk(clk), .rst(rst), .in_valid(in_valid), .PC_in(pc), .Instruction(instr),
      .status(status), .Dest_wb(dwb), .Result_WB(wres_s), .writeBackEn(wbe),
      .Hazard(hazard), .freeze(freeze), .flush(flush),
      .src1(s_src1), .src2(s_src2), .has_src2(s_has2), .out_valid(s_v), .WB_EN(s_wb),
      .MEM_R_EN(s_mr), .MEM_W_EN(s_mw), .B(s_b), .S(s_s), .imm(s_imm), .EXE_CMD(s_cmd),
      .PC_out(s_pc), .Val_RN(s_rn), .Val_RM(s_rm), .Dest(s_dest),
      .shift_operand(s_sh), .imm24_sext(s_simm)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] dmask(input int d);
      return (d == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
   endfunction

   // Conditions come in complementary pairs: even code tests the base, odd code inverts it.
   function automatic logic cond_true(input logic [3:0] c, input logic [3:0] st);
      logic z, cf, n, v, base;
      z = st[3]; cf = st[2]; n = st[1]; v = st[0];
      if (c >= 4'hE) return 1'b1;
      case (c[3:1])
         3'd0: base = z;
         3'd1: base = cf;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = cf & ~z;
         3'd5: base = (n == v);
         default: base = ~z & (n == v);
      endcase
      return base ^ c[0];
   endfunction

   function automatic logic [31:0] mread(input int d, input logic [3:0] idx);
      int n;
      logic [31:0] val;
      n = (d == 0) ? 16 : 8;
      if (int'(idx) >= n) return 32'h0;
      val = m_reg[d][idx];
`ifdef WB_BYPASS_EN
      if (wbe && idx == dwb) val = wres & dmask(d);
`endif
      return val;
   endfunction

   function automatic bundle_t predict(input int d);
      bundle_t e = '{default: '0};
      logic [1:0] mode;
      logic store;
      mode = instr[27:26];
      if (!in_valid || hazard || mode == 2'b11 || !cond_true(instr[31:28], status)) return e;
      store  = (mode == 2'b01) && !instr[20];
      e.v    = 1'b1;
      e.pc   = pc;
      e.dest = instr[15:12];
      e.sh   = instr[11:0];
      e.simm = instr[23] ? 32'(instr[23:0]) - 32'h0100_0000 : 32'(instr[23:0]);
      e.rn   = mread(d, instr[19:16]);
      e.rm   = mread(d, store ? instr[15:12] : instr[3:0]);
      if (mode == 2'b00) begin
         e.imm = instr[25];
         for (int k = 0; k < 11; k++)
            if (opc_tab[k] == instr[24:21]) begin
               e.cmd = cmd_tab[k];
               e.wb  = (instr[24:21] != 4'hA) && (instr[24:21] != 4'h8);
               e.s   = instr[20];
            end
      end else if (mode == 2'b01) begin
         e.imm = instr[25];
         e.cmd = 4'b0010;
         e.mr  = instr[20];
         e.wb  = instr[20];
         e.mw  = !instr[20];
      end else begin
         e.b = 1'b1;
      end
      return e;
   endfunction

   function automatic bundle_t obs(input int d);
      bundle_t o;
      if (d == 0) begin
         o.v = b_v; o.wb = b_wb; o.mr = b_mr; o.mw = b_mw; o.b = b_b; o.s = b_s; o.imm = b_imm;
         o.cmd = b_cmd; o.dest = b_dest; o.pc = b_pc; o.rn = b_rn; o.rm = b_rm;
         o.simm = b_simm; o.sh = b_sh;
      end else begin
         o.v = s_v; o.wb = s_wb; o.mr = s_mr; o.mw = s_mw; o.b = s_b; o.s = s_s; o.imm = s_imm;
         o.cmd = s_cmd; o.dest = s_dest; o.pc = s_pc; o.rn = 32'(s_rn); o.rm = 32'(s_rm);
         o.simm = s_simm; o.sh = s_sh;
      end
      return o;
   endfunction

   task automatic compare(input int d);
      bundle_t o, e;
      string p;
      o = obs(d);
      e = exp_q[d];
      p = (d == 0) ? "big." : "small.";
      check({p, "out_valid"}, 32'(o.v), 32'(e.v));
      check({p, "WB_EN"}, 32'(o.wb), 32'(e.wb));
      check({p, "MEM_R_EN"}, 32'(o.mr), 32'(e.mr));
      check({p, "MEM_W_EN"}, 32'(o.mw), 32'(e.mw));
      check({p, "B"}, 32'(o.b), 32'(e.b));
      check({p, "S"}, 32'(o.s), 32'(e.s));
      check({p, "imm"}, 32'(o.imm), 32'(e.imm));
      check({p, "EXE_CMD"}, 32'(o.cmd), 32'(e.cmd));
      check({p, "Dest"}, 32'(o.dest), 32'(e.dest));
      check({p, "PC_out"}, o.pc, e.pc);
      check({p, "Val_RN"}, o.rn, e.rn);
      check({p, "Val_RM"}, o.rm, e.rm);
      check({p, "imm24_sext"}, o.simm, e.simm);
      check({p, "shift_operand"}, 32'(o.sh), 32'(e.sh));
   endtask

   task automatic tick();
      bundle_t nxt [2];
      logic store;
      #1;
      store = (instr[27:26] == 2'b01) && !instr[20];
      check("src1", 32'(b_src1), 32'(instr[19:16]));
      check("src2", 32'(b_src2), 32'(store ? instr[15:12] : instr[3:0]));
      check("has_src2", 32'(b_has2), 32'(!instr[25] || store));
      check("small.src2", 32'(s_src2), 32'(store ? instr[15:12] : instr[3:0]));
      for (int d = 0; d < 2; d++) begin
         if (rst || flush) nxt[d] = '{default: '0};
         else if (freeze)  nxt[d] = exp_q[d];
         else              nxt[d] = predict(d);
      end
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            for (int r = 0; r < 16; r++) m_reg[d][r] = 32'h0;
         end else if (wbe && int'(dwb) < ((d == 0) ? 16 : 8)) begin
            m_reg[d][dwb] = wres & dmask(d);
         end
      end
      @(posedge clk);
      #1;
      exp_q = nxt;
      compare(0);
      compare(1);
   endtask

   task automatic writeback(input logic [3:0] idx, input logic [31:0] val);
      wbe = 1'b1; dwb = idx; wres = val;
      tick();
      wbe = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; wbe = 1'b0; hazard = 1'b0; freeze = 1'b0; flush = 1'b0;
      pc = 32'h0; instr = 32'h0; wres = 32'h0; status = 4'h0; dwb = 4'h0;
      exp_q[0] = '{default: '0};
      exp_q[1] = '{default: '0};

      tick();
      tick();
      check("rst_out_valid", 32'(b_v), 32'h0);
      check("rst_Val_RN", b_rn, 32'h0);
      rst = 1'b0;

      writeback(4'd1, 32'd5);
      writeback(4'd3, 32'd7);

      in_valid = 1'b1; pc = 32'h100; instr = 32'hE081_2003; status = 4'h0;
      tick();
      check("add_valid", 32'(b_v), 32'h1);
      check("add_cmd", 32'(b_cmd), 32'h2);
      check("add_wb", 32'(b_wb), 32'h1);
      check("add_rn", b_rn, 32'd5);
      check("add_rm", b_rm, 32'd7);
      check("add_dest", 32'(b_dest), 32'd2);

      instr = 32'h03A0_0001; status = 4'b0000;
      tick();
      check("moveq_valid", 32'(b_v), 32'h0);
      check("moveq_wb", 32'(b_wb), 32'h0);

      instr = 32'hE581_2000;
      tick();
      check("str_memw", 32'(b_mw), 32'h1);
      check("str_wb", 32'(b_wb), 32'h0);
      check("str_src2", 32'(b_src2), 32'h2);
      check("str_has_src2", 32'(b_has2), 32'h1);
      hazard = 1'b1;
      tick();
      check("str_hazard_valid", 32'(b_v), 32'h0);
      hazard = 1'b0;

      instr = 32'hE081_2003; wbe = 1'b1; dwb = 4'd1; wres = 32'hAA;
      tick();
      wbe = 1'b0;
`ifdef WB_BYPASS_EN
      check("bypass_rn", b_rn, 32'hAA);
`else
      check("bypass_rn", b_rn, 32'd5);
`endif
      tick();
      check("r1_after_wb", b_rn, 32'hAA);

      freeze = 1'b1;
      for (int n = 0; n < 3; n++) begin
         instr = $urandom; pc = $urandom;
         tick();
         check("freeze_hold_rn", b_rn, 32'hAA);
         check("freeze_hold_cmd", 32'(b_cmd), 32'h2);
      end
      flush = 1'b1;
      tick();
      check("freeze_flush_valid", 32'(b_v), 32'h0);
      freeze = 1'b0; flush = 1'b0;

      in_valid = 1'b0;
      writeback(4'd9, 32'h1234);
      writeback(4'd3, 32'h0001_BEEF);
      in_valid = 1'b1; instr = 32'hE089_2003;
      tick();
      check("small_idx9_rn", 32'(s_rn), 32'h0);
      check("small_rm_16b", 32'(s_rm), 32'hBEEF);
      check("big_idx9_rn", b_rn, 32'h1234);

      for (int n = 0; n < 800; n++) begin
         rst      = ($urandom_range(0, 99) < 2);
         in_valid = ($urandom_range(0, 9) != 0);
         hazard   = ($urandom_range(0, 9) == 0);
         freeze   = ($urandom_range(0, 9) == 0);
         flush    = ($urandom_range(0, 19) == 0);
         wbe      = ($urandom_range(0, 1) == 1);
         dwb      = 4'($urandom);
         wres     = $urandom;
         status   = 4'($urandom);
         pc       = $urandom;
         instr    = $urandom;
         if ($urandom_range(0, 1) == 1) instr[31:28] = 4'hE;
         if ($urandom_range(0, 2) == 0) instr[19:16] = dwb;
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
